// File: rtl/syn_fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: defaults, read-mode
// encodings and an elaboration-time log2 helper.
package syn_fifo_pkg;

    localparam int FIFO_DEF_WIDTH = 8;
    localparam int FIFO_DEF_DEPTH = 16;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Ceiling log2, usable in parameter defaults.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/syn_fifo_ram.sv
// DEPTH x WIDTH storage array: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module syn_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/syn_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty
// thresholds, sticky overflow/underflow and selectable FWFT read mode.
module syn_fifo_flags
    import syn_fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_DEF_WIDTH,
    parameter int DEPTH     = FIFO_DEF_DEPTH,
    parameter int AF_LEVEL  = DEPTH - 4,
    parameter int AE_LEVEL  = 4,
    parameter int FWFT      = FIFO_MODE_STD,
    parameter int PTR_WIDTH = clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               res,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               rd_en,
    output logic [WIDTH-1:0]   rdata,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [PTR_WIDTH:0] count,
    output logic               overflow,
    output logic               underflow,
    input  logic               err_clr
);

    localparam logic [PTR_WIDTH:0] CNT_FULL = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] CNT_AF   = (PTR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [PTR_WIDTH:0] CNT_AE   = (PTR_WIDTH + 1)'(AE_LEVEL);
    localparam logic [PTR_WIDTH:0] PTR_ONE  = (PTR_WIDTH + 1)'(1);

    logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0] count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               wr_acc, rd_acc;
    logic [WIDTH-1:0]   ram_rdata;

    // Flags depend on the count register alone, never on the request inputs.
    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q & ~err_clr;
        underflow_d = underflow_q & ~err_clr;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase

        // A fresh error outranks a same-cycle clear.
        if (wr_en & full) begin
            overflow_d = 1'b1;
        end
        if (rd_en & empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Wrap bits only distinguish laps; occupancy is tracked by count_q.
    logic unused_wrap_bits;
    assign unused_wrap_bits = wr_ptr_q[PTR_WIDTH] ^ rd_ptr_q[PTR_WIDTH];

    syn_fifo_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (PTR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_acc),
        .waddr(wr_ptr_q[PTR_WIDTH-1:0]),
        .wdata(wdata),
        .raddr(rd_ptr_q[PTR_WIDTH-1:0]),
        .rdata(ram_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is presented directly; forced to zero while empty so reset
        // clears the output without a clock edge.
        assign rdata = empty ? '0 : ram_rdata;
    end else begin : g_std
        logic [WIDTH-1:0] rdata_q, rdata_d;

        always_comb begin
            rdata_d = rdata_q;
            if (rd_acc) begin
                rdata_d = ram_rdata;
            end
        end

        always_ff @(posedge clk or posedge res) begin
            if (res) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign rdata = rdata_q;
    end

endmodule

// File: tb/tb_syn_fifo_flags.sv
// Bench for syn_fifo_flags: a registered-read and an FWFT instance share one
// stimulus stream and are compared against a queue-based occupancy model.
module tb_syn_fifo_flags;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AF = 12;
    localparam int AE = 4;

    logic         clk = 1'b0;
    logic         res = 1'b1;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic         err_clr = 1'b0;
    logic [W-1:0] wdata = '0;

    logic [W-1:0] rdata_s, rdata_f;
    logic         full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
    logic         full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
    logic [4:0]   count_s, count_f;

    int errors = 0;
    int checks = 0;

    // Reference model
    logic [W-1:0] mq[$];
    logic [W-1:0] m_rd = '0;
    bit           m_ovf = 1'b0;
    bit           m_unf = 1'b0;

    always #5 clk = ~clk;

    syn_fifo_flags #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
        .clk(clk), .res(res), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata_s), .full(full_s), .empty(empty_s), .almost_full(af_s),
        .almost_empty(ae_s), .count(count_s), .overflow(ovf_s), .underflow(unf_s),
        .err_clr(err_clr)
    );

    syn_fifo_flags #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
        .clk(clk), .res(res), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
        .almost_empty(ae_f), .count(count_f), .overflow(ovf_f), .underflow(unf_f),
        .err_clr(err_clr)
    );

    // Drive one cycle of requests, advance the model at the edge, return 1ns after it.
    task automatic step(input logic w, input logic [W-1:0] d, input logic r, input logic c);
        bit was_full, was_empty;
        @(negedge clk);
        wr_en = w; wdata = d; rd_en = r; err_clr = c;
        @(posedge clk);
        was_full  = (mq.size() == D);
        was_empty = (mq.size() == 0);
        if (r && !was_empty) m_rd = mq.pop_front();
        if (w && !was_full) mq.push_back(d);
        m_ovf = (w && was_full) || (m_ovf && !c);
        m_unf = (r && was_empty) || (m_unf && !c);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_rd  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        res = 1'b0;
        model_reset();
        #1;
        checks++; if (count_s !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_s); end
        checks++; if ({empty_s, ae_s, full_s, af_s} !== 4'b1100) begin errors++; $display("FAIL reset_flags got %b want 1100", {empty_s, ae_s, full_s, af_s}); end
        checks++; if ({ovf_s, unf_s, ovf_f, unf_f} !== 4'b0000) begin errors++; $display("FAIL reset_err got %b want 0000", {ovf_s, unf_s, ovf_f, unf_f}); end
        checks++; if (rdata_s !== 8'h00 || rdata_f !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h/%h want 00/00", rdata_s, rdata_f); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= D; i++) begin
            step(1'b1, W'(i), 1'b0, 1'b0);
            checks++; if (count_s !== 5'(i)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count_s, i); end
            checks++; if (ae_s !== (i <= AE)) begin errors++; $display("FAIL fill_ae[%0d] got %b want %b", i, ae_s, (i <= AE)); end
            checks++; if (af_s !== (i >= AF)) begin errors++; $display("FAIL fill_af[%0d] got %b want %b", i, af_s, (i >= AF)); end
            checks++; if (full_s !== (i == D)) begin errors++; $display("FAIL fill_full[%0d] got %b want %b", i, full_s, (i == D)); end
            checks++; if (rdata_f !== 8'h01) begin errors++; $display("FAIL fill_fwft_head[%0d] got %h want 01", i, rdata_f); end
        end
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        checks++; if (ovf_s !== 1'b1 || ovf_f !== 1'b1) begin errors++; $display("FAIL overflow got %b/%b want 1/1", ovf_s, ovf_f); end
        checks++; if (count_s !== 5'd16 || full_s !== 1'b1) begin errors++; $display("FAIL ovf_count got %0d full %b want 16 full 1", count_s, full_s); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= D; i++) begin
            checks++; if (rdata_f !== W'(i)) begin errors++; $display("FAIL drain_fwft[%0d] got %h want %h", i, rdata_f, W'(i)); end
            step(1'b0, '0, 1'b1, 1'b0);
            checks++; if (rdata_s !== W'(i)) begin errors++; $display("FAIL drain_std[%0d] got %h want %h", i, rdata_s, W'(i)); end
        end
        checks++; if (empty_s !== 1'b1 || count_s !== 5'd0) begin errors++; $display("FAIL drain_empty got %b cnt %0d want 1 cnt 0", empty_s, count_s); end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (unf_s !== 1'b1) begin errors++; $display("FAIL underflow got %b want 1", unf_s); end
        checks++; if (rdata_s !== 8'h10) begin errors++; $display("FAIL rdata_hold got %h want 10", rdata_s); end
    endtask

    task automatic test_wrap();
        int peak;
        bit saw_full;
        peak = 0; saw_full = 1'b0;
        for (int lap = 0; lap < 2; lap++) begin
            for (int i = 0; i < 10; i++) begin
                step(1'b1, W'(lap * 10 + i), 1'b0, 1'b0);
                if (int'(count_s) > peak) peak = int'(count_s);
                if (full_s) saw_full = 1'b1;
            end
            for (int i = 0; i < 10; i++) begin
                step(1'b0, '0, 1'b1, 1'b0);
                checks++; if (rdata_s !== W'(lap * 10 + i)) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", lap * 10 + i, rdata_s, W'(lap * 10 + i)); end
            end
        end
        checks++; if (peak != 10 || saw_full) begin errors++; $display("FAIL wrap_peak got %0d full_seen %b want 10 full_seen 0", peak, saw_full); end
    endtask

    task automatic test_simultaneous();
        step(1'b0, '0, 1'b0, 1'b1);
        checks++; if ({ovf_s, unf_s} !== 2'b00) begin errors++; $display("FAIL clr_before_simul got %b want 00", {ovf_s, unf_s}); end
        step(1'b1, 8'h30, 1'b1, 1'b0);
        checks++; if (count_s !== 5'd1 || {ovf_s, unf_s} !== 2'b01) begin errors++; $display("FAIL simul_empty got cnt %0d err %b want cnt 1 err 01", count_s, {ovf_s, unf_s}); end
        for (int i = 1; i < D; i++) step(1'b1, W'(8'h30 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 8'h40, 1'b1, 1'b0);
        checks++; if (count_s !== 5'd15 || {ovf_s, unf_s} !== 2'b10) begin errors++; $display("FAIL simul_full got cnt %0d err %b want cnt 15 err 10", count_s, {ovf_s, unf_s}); end
        checks++; if (rdata_s !== 8'h30) begin errors++; $display("FAIL simul_full_data got %h want 30", rdata_s); end
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 8'h41, 1'b1, 1'b0);
        checks++; if (count_s !== 5'd8 || {ovf_s, unf_s} !== 2'b00) begin errors++; $display("FAIL simul_mid got cnt %0d err %b want cnt 8 err 00", count_s, {ovf_s, unf_s}); end
        checks++; if (rdata_s !== 8'h38) begin errors++; $display("FAIL simul_mid_data got %h want 38", rdata_s); end
    endtask

    task automatic test_err_clear();
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (rdata_s !== 8'h41 || empty_s !== 1'b1) begin errors++; $display("FAIL errclr_drain got %h empty %b want 41 empty 1", rdata_s, empty_s); end
        step(1'b0, '0, 1'b1, 1'b1);
        checks++; if (unf_s !== 1'b1 || unf_f !== 1'b1) begin errors++; $display("FAIL set_wins got %b/%b want 1/1", unf_s, unf_f); end
        checks++; if (count_s !== 5'd0) begin errors++; $display("FAIL unf_count got %0d want 0", count_s); end
        step(1'b0, '0, 1'b0, 1'b1);
        checks++; if ({ovf_s, unf_s} !== 2'b00) begin errors++; $display("FAIL err_clr got %b want 00", {ovf_s, unf_s}); end
    endtask

    task automatic test_fwft_reset();
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        checks++; if (rdata_f !== 8'hA5 || empty_f !== 1'b0) begin errors++; $display("FAIL fwft_first got %h empty %b want a5 empty 0", rdata_f, empty_f); end
        checks++; if (rdata_s !== 8'h41) begin errors++; $display("FAIL std_no_fallthrough got %h want 41", rdata_s); end
        for (int i = 0; i < 6; i++) step(1'b1, W'(8'hB0 + i), 1'b0, 1'b0);
        checks++; if (count_f !== 5'd7) begin errors++; $display("FAIL fwft_count got %0d want 7", count_f); end
        @(negedge clk);
        #2;
        res = 1'b1;
        #1;
        model_reset();
        checks++; if (count_s !== 5'd0 || count_f !== 5'd0) begin errors++; $display("FAIL async_count got %0d/%0d want 0/0", count_s, count_f); end
        checks++; if (empty_s !== 1'b1 || empty_f !== 1'b1) begin errors++; $display("FAIL async_empty got %b/%b want 1/1", empty_s, empty_f); end
        checks++; if (rdata_s !== 8'h00 || rdata_f !== 8'h00) begin errors++; $display("FAIL async_rdata got %h/%h want 00/00", rdata_s, rdata_f); end
        @(negedge clk);
        res = 1'b0;
    endtask

    task automatic test_random();
        int n;
        logic [W-1:0] exp_head;
        for (int i = 0; i < 400; i++) begin
            case (i / 100)
                0:       step($urandom_range(99) < 75, W'($urandom), $urandom_range(99) < 30, $urandom_range(99) < 8);
                1:       step($urandom_range(99) < 30, W'($urandom), $urandom_range(99) < 75, $urandom_range(99) < 8);
                default: step($urandom_range(1), W'($urandom), $urandom_range(1), $urandom_range(99) < 8);
            endcase
            n = mq.size();
            checks++; if (count_s !== 5'(n) || count_f !== 5'(n)) begin errors++; $display("FAIL rnd_count[%0d] got %0d/%0d want %0d", i, count_s, count_f, n); end
            checks++; if ({full_s, empty_s, af_s, ae_s} !== {n == D, n == 0, n >= AF, n <= AE}) begin errors++; $display("FAIL rnd_flags[%0d] got %b want %b", i, {full_s, empty_s, af_s, ae_s}, {n == D, n == 0, n >= AF, n <= AE}); end
            checks++; if ({ovf_s, unf_s} !== {m_ovf, m_unf}) begin errors++; $display("FAIL rnd_err[%0d] got %b want %b", i, {ovf_s, unf_s}, {m_ovf, m_unf}); end
            checks++; if (rdata_s !== m_rd) begin errors++; $display("FAIL rnd_std_rdata[%0d] got %h want %h", i, rdata_s, m_rd); end
            if (n > 0) begin
                exp_head = mq[0];
                checks++; if (rdata_f !== exp_head) begin errors++; $display("FAIL rnd_fwft_rdata[%0d] got %h want %h", i, rdata_f, exp_head); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_err_clear();
        test_fwft_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
